// File: rtl/morse_tx_fifo.sv
// morse_tx_fifo: queues A-Z letter indices in a FIFO and keys them as Morse code on one LED.
module morse_tx_fifo #(
    parameter int TICK_DIV      = 25000000,
    parameter int DASH_UNITS    = 3,
    parameter int SYM_GAP_UNITS = 1,
    parameter int LTR_GAP_UNITS = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int UNIT_W        = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [4:0]                    letter_in,
    input  logic                          letter_valid,
    output logic                          letter_ready,
    input  logic                          abort,
    output logic                          led,
    output logic                          busy,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL     = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0]     TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [UNIT_W-1:0] DASH_U   = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] SYM_U    = UNIT_W'(SYM_GAP_UNITS);
    localparam logic [UNIT_W-1:0] LTR_U    = UNIT_W'(LTR_GAP_UNITS);
    localparam logic [UNIT_W-1:0] ONE_U    = UNIT_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, LGAP} state_t;

    state_t            state, state_n;
    logic [4:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [4:0]        idx;
    logic [TW-1:0]     tcnt;
    logic [UNIT_W-1:0] units, units_n;
    logic [3:0]        code, code_n;
    logic [2:0]        len, len_n;
    logic [6:0]        rom;
    logic              led_n, push, pop, tick, timed;

    // {length, code left-aligned so the next symbol is always bit 3}, 1 = dash
    function automatic logic [6:0] morse_rom(input logic [4:0] i);
        case (i)
            5'd0:    return {3'd2, 4'b0100};
            5'd1:    return {3'd4, 4'b1000};
            5'd2:    return {3'd4, 4'b1010};
            5'd3:    return {3'd3, 4'b1000};
            5'd4:    return {3'd1, 4'b0000};
            5'd5:    return {3'd4, 4'b0010};
            5'd6:    return {3'd3, 4'b1100};
            5'd7:    return {3'd4, 4'b0000};
            5'd8:    return {3'd2, 4'b0000};
            5'd9:    return {3'd4, 4'b0111};
            5'd10:   return {3'd3, 4'b1010};
            5'd11:   return {3'd4, 4'b0100};
            5'd12:   return {3'd2, 4'b1100};
            5'd13:   return {3'd2, 4'b1000};
            5'd14:   return {3'd3, 4'b1110};
            5'd15:   return {3'd4, 4'b0110};
            5'd16:   return {3'd4, 4'b1101};
            5'd17:   return {3'd3, 4'b0100};
            5'd18:   return {3'd3, 4'b0000};
            5'd19:   return {3'd1, 4'b1000};
            5'd20:   return {3'd3, 4'b0010};
            5'd21:   return {3'd4, 4'b0001};
            5'd22:   return {3'd3, 4'b0110};
            5'd23:   return {3'd4, 4'b1001};
            5'd24:   return {3'd4, 4'b1011};
            5'd25:   return {3'd4, 4'b1100};
            default: return 7'd0;
        endcase
    endfunction

    assign rom          = morse_rom(idx);
    assign letter_ready = fifo_count != FULL;
    assign push         = letter_valid && letter_ready && !abort;
    assign pop          = state == IDLE && fifo_count != '0 && !abort;
    assign tick         = tcnt == TICK_MAX;
    assign timed        = state == MARK || state == SPACE || state == LGAP;
    assign busy         = state != IDLE;
    assign err          = state == LOAD && idx > 5'd25;

    always_ff @(posedge CLOCK_50)
        if (push) mem[wptr] <= letter_in;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            idx        <= '0;
        end else if (abort) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                idx  <= mem[rptr];
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code;
        len_n   = len;
        units_n = units;
        case (state)
            IDLE: state_n = pop ? LOAD : IDLE;
            LOAD: begin
                code_n  = rom[3:0];
                len_n   = rom[6:4];
                units_n = rom[3] ? DASH_U : ONE_U;
                state_n = idx > 5'd25 ? IDLE : MARK;
            end
            MARK: if (tick) begin
                if (units != ONE_U) units_n = units - 1'b1;
                else if (len > 3'd1) begin
                    code_n  = code << 1;
                    len_n   = len - 3'd1;
                    units_n = SYM_U;
                    state_n = SPACE;
                end else begin
                    units_n = LTR_U;
                    state_n = LGAP;
                end
            end
            SPACE: if (tick) begin
                units_n = units != ONE_U ? units - 1'b1 : (code[3] ? DASH_U : ONE_U);
                state_n = units != ONE_U ? SPACE : MARK;
            end
            LGAP: if (tick) begin
                units_n = units - 1'b1;
                state_n = units != ONE_U ? LGAP : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
        led_n = state_n == MARK;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            code  <= '0;
            len   <= '0;
            units <= '0;
            led   <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
            len   <= len_n;
            units <= units_n;
            led   <= led_n;
            tcnt  <= (timed && !tick && !abort) ? tcnt + 1'b1 : '0;
        end
    end
endmodule
